xnor_sweep_checker: RTL
=======================

Name: xnor_sweep_checker

Overview:
Synthesizable response checker that forms the receive side of the xnor_compare stimulus sweep. The sweep driver applies (a,b,c) vectors to xnor_compare; this block samples each applied vector together with both DUT outputs. For every vector it computes the expected 3-input XNOR, counts mismatches and records which of the 8 input combinations have been seen. It flags pass/fail when the sweep completes, stalls or overruns, so self-checking runs on FPGA or in simulation need no waveform inspection.

Parameters:
CNT_W, 8, width of vec_cnt and err_cnt.
MAX_VECTORS, 64, maximum accepted vectors per run before forced DONE (1..2^CNT_W-1).
TIMEOUT, 16, idle cycles in RUN without obs_valid before timeout; 0 disables.

Ports:
clk  in  1  single clock; all state changes on rising edge.
rst_n  in  1  asynchronous, active-low reset.
start  in  1  1-cycle pulse; clears statistics and enters RUN.
obs_valid  in  1  obs_* inputs hold a valid vector this cycle.
obs_a, obs_b, obs_c  in  1 each  applied input vector.
obs_out_3in  in  1  DUT 3-input primitive output.
obs_out_inst  in  1  DUT instantiated-gate output.
busy  out  1  state == RUN.
done  out  1  state == DONE.
pass  out  1  run succeeded (valid only while done).
timeout  out  1  run ended by TIMEOUT.
mismatch  out  1  1-cycle pulse: last accepted vector failed.
vec_cnt  out  CNT_W  accepted vectors this run.
err_cnt  out  CNT_W  failing vectors this run (saturating).
coverage  out  8  bit {a,b,c} set when that combination is accepted.
first_err_valid  out  1  first_err_vec holds data.
first_err_vec  out  3  {a,b,c} of the first failing vector.

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output and internal counter cleared to 0. Takes effect immediately, including mid-run. After release, stays in IDLE until start.
- Expected value: exp = ~(obs_a ^ obs_b ^ obs_c).
- A vector fails if obs_out_3in != exp or obs_out_inst != exp. One fail adds one to err_cnt, even if both outputs are wrong.
- States: IDLE, RUN, DONE.
  - start in any state: clears vec_cnt, err_cnt, coverage, first_err_*, timeout and mismatch; next state RUN.
  - obs_valid in the same cycle as start is ignored.
  - RUN, obs_valid=1 (vector accepted) at edge E. All of the following are registered at E:
    - vec_cnt+1
    - coverage[{a,b,c}]=1
    - mismatch = fail
    - err_cnt+fail, saturating at 2^CNT_W-1
    - if fail and !first_err_valid: first_err_vec={a,b,c}, first_err_valid=1
    - idle counter cleared.
  - RUN, end of run: if the updated coverage == 8'hFF or the updated vec_cnt == MAX_VECTORS, state becomes DONE at E. done=1 is visible from E, so zero extra latency.
  - RUN, obs_valid=0: mismatch=0 and the idle counter increments. If TIMEOUT != 0 and the counter reaches TIMEOUT, state becomes DONE with timeout=1.
  - IDLE and DONE: obs_valid is ignored and counters are frozen. mismatch returns to 0 one cycle after its pulse.
- pass = done & (err_cnt==0) & (coverage==8'hFF) & ~timeout. It is combinational from registers and 0 outside DONE.
- Duplicate vectors count in vec_cnt but leave coverage unchanged.
- X/Z on obs_* while obs_valid=0 must not affect state.

Test Plan:
- Exhaustive good sweep: start, then 000..111 on consecutive cycles with correct outputs → done=1 at the 8th vector edge, vec_cnt=8, err_cnt=0, coverage=8'hFF, pass=1, mismatch never asserted.
- Fault injection: same sweep, but vector 011 drives out_inst=0 (exp=1) → mismatch pulses one cycle. Final err_cnt=1, first_err_valid=1, first_err_vec=3'b011, done=1, pass=0.
- Coverage hole: 64 vectors all 000 with correct outputs → done at vector 64, vec_cnt=64, coverage=8'h01, pass=0, timeout=0.
- Timeout: start, 2 good vectors, then obs_valid=0 for 16 cycles → done=1 and timeout=1 on the 16th idle edge, vec_cnt=2, pass=0.
- Reset mid-run: after 4 vectors, pulse rst_n low (asynchronously, between edges) → all outputs 0 immediately. A subsequent full good sweep gives vec_cnt=8, pass=1.
- Restart from DONE: after a failing run, start plus a simultaneous obs_valid → the simultaneous vector is ignored and stats are cleared. A good sweep then gives vec_cnt=8, err_cnt=0, pass=1.

Source files
------------

// File: rtl/xnor_sweep_checker.sv
// Receive-side checker for the xnor_compare stimulus sweep: checks each applied
// vector against the expected 3-input XNOR and tracks errors and coverage.
module xnor_sweep_checker #(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned MAX_VECTORS = 64,
  parameter int unsigned TIMEOUT     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             obs_valid,
  input  logic             obs_a,
  input  logic             obs_b,
  input  logic             obs_c,
  input  logic             obs_out_3in,
  input  logic             obs_out_inst,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             mismatch,
  output logic [CNT_W-1:0] vec_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [7:0]       coverage,
  output logic             first_err_valid,
  output logic [2:0]       first_err_vec
);

  localparam int unsigned IDLE_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state;
  logic [IDLE_W-1:0] idle_cnt;

  logic [2:0]        vec_idx;
  logic              exp_bit;
  logic              fail;
  logic [CNT_W-1:0]  vec_nxt;
  logic [7:0]        cov_nxt;
  logic [IDLE_W-1:0] idle_nxt;
  logic              run_end;
  logic              idle_expire;

  // Per-vector evaluation and the end-of-run conditions on updated statistics
  assign vec_idx     = {obs_a, obs_b, obs_c};
  assign exp_bit     = ~(obs_a ^ obs_b ^ obs_c);
  assign fail        = (obs_out_3in != exp_bit) | (obs_out_inst != exp_bit);
  assign vec_nxt     = vec_cnt + CNT_W'(1);
  assign cov_nxt     = coverage | (8'b1 << vec_idx);
  assign idle_nxt    = idle_cnt + IDLE_W'(1);
  assign run_end     = (cov_nxt == 8'hFF) || (vec_nxt == CNT_W'(MAX_VECTORS));
  assign idle_expire = (TIMEOUT != 0) && (idle_nxt == IDLE_W'(TIMEOUT));

  // Status decoded straight from registered state and statistics
  assign busy = (state == S_RUN);
  assign done = (state == S_DONE);
  assign pass = done & (err_cnt == '0) & (coverage == 8'hFF) & ~timeout;

  // Run-control FSM and statistics registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= S_IDLE;
      idle_cnt        <= '0;
      timeout         <= 1'b0;
      mismatch        <= 1'b0;
      vec_cnt         <= '0;
      err_cnt         <= '0;
      coverage        <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else if (start) begin
      state           <= S_RUN;
      idle_cnt        <= '0;
      timeout         <= 1'b0;
      mismatch        <= 1'b0;
      vec_cnt         <= '0;
      err_cnt         <= '0;
      coverage        <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      case (state)
        S_RUN: begin
          if (obs_valid) begin
            vec_cnt  <= vec_nxt;
            coverage <= cov_nxt;
            mismatch <= fail;
            idle_cnt <= '0;
            if (fail && (err_cnt != {CNT_W{1'b1}})) begin
              err_cnt <= err_cnt + CNT_W'(1);
            end
            if (fail && !first_err_valid) begin
              first_err_valid <= 1'b1;
              first_err_vec   <= vec_idx;
            end
            if (run_end) begin
              state <= S_DONE;
            end
          end else begin
            mismatch <= 1'b0;
            idle_cnt <= idle_nxt;
            if (idle_expire) begin
              state   <= S_DONE;
              timeout <= 1'b1;
            end
          end
        end
        default: begin
          mismatch <= 1'b0;
        end
      endcase
    end
  end

endmodule
